// File: rtl/data_bus_bridge.sv
// Bridges the core's per-cycle data-memory access onto a single-outstanding valid/ready
// request channel with a response channel, stalling the core via core_clk_en until done.
module data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en_in,
  output logic        core_clk_en,
  input  logic        core_bus_lock,
  input  logic        core_memory_mode,
  input  logic [29:0] core_address,
  input  logic [3:0]  core_mask,
  input  logic [31:0] core_data_out,
  output logic [31:0] core_data_in,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [29:0] req_addr,
  output logic [3:0]  req_mask,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_err,
  input  logic        err_clr,
  output logic        bus_error,
  output logic        busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             req_valid_q;
  logic             req_write_q;
  logic [29:0]      req_addr_q;
  logic [3:0]       req_mask_q;
  logic [31:0]      req_wdata_q;
  logic [31:0]      core_data_in_q;
  logic             bus_error_q;

  logic rsp_take;
  logic timeout;
  logic err_set;

  // A response counts only in WAIT, or in REQ on the very cycle the request is accepted.
  assign rsp_take = rsp_valid &&
                    ((state_q == StWait) || ((state_q == StReq) && req_ready));

  assign timeout = TimeoutEn && ((state_q == StReq) || (state_q == StWait)) &&
                   (cnt_q == CntLast) && !rsp_take;

  assign err_set = (rsp_take && rsp_err) || timeout;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      req_valid_q    <= 1'b0;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_mask_q     <= '0;
      req_wdata_q    <= '0;
      core_data_in_q <= '0;
      bus_error_q    <= 1'b0;
    end else begin
      if (err_set) begin
        bus_error_q <= 1'b1;
      end else if (err_clr) begin
        bus_error_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (core_bus_lock) begin
            req_write_q <= core_memory_mode;
            req_addr_q  <= core_address;
            req_mask_q  <= core_mask;
            req_wdata_q <= core_data_out;
            req_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StReq;
          end
        end
        StReq, StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (rsp_take || timeout) begin
            req_valid_q <= 1'b0;
            state_q     <= StDone;
            if (!req_write_q) begin
              core_data_in_q <= (timeout || rsp_err) ? ERR_DATA : rsp_rdata;
            end
          end else if ((state_q == StReq) && req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StDone: begin
          // The core still shows bus_lock for the finished access here; ignore it.
          if (clk_en_in) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_clk_en  = clk_en_in &&
                        (((state_q == StIdle) && !core_bus_lock) || (state_q == StDone));
  assign busy         = (state_q != StIdle);
  assign req_valid    = req_valid_q;
  assign req_write    = req_write_q;
  assign req_addr     = req_addr_q;
  assign req_mask     = req_mask_q;
  assign req_wdata    = req_wdata_q;
  assign core_data_in = core_data_in_q;
  assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge: stimulus queues expected requests/completions,
// a negedge monitor pops and compares them when the DUT presents a handshake or completion.
module tb_data_bus_bridge;

  logic        clk;
  logic        async_rst_n;
  logic        clk_en_in;
  logic        core_clk_en;
  logic        core_bus_lock;
  logic        core_memory_mode;
  logic [29:0] core_address;
  logic [3:0]  core_mask;
  logic [31:0] core_data_out;
  logic [31:0] core_data_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [29:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        err_clr;
  logic        bus_error;
  logic        busy;

  data_bus_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEADBEEF)
  ) dut (
    .clk             (clk),
    .async_rst_n     (async_rst_n),
    .clk_en_in       (clk_en_in),
    .core_clk_en     (core_clk_en),
    .core_bus_lock   (core_bus_lock),
    .core_memory_mode(core_memory_mode),
    .core_address    (core_address),
    .core_mask       (core_mask),
    .core_data_out   (core_data_out),
    .core_data_in    (core_data_in),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_mask        (req_mask),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .err_clr         (err_clr),
    .bus_error       (bus_error),
    .busy            (busy)
  );

  typedef struct packed {
    logic        w;
    logic [29:0] a;
    logic [3:0]  m;
    logic [31:0] d;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } cmp_t;

  req_t exp_req_q[$];
  cmp_t exp_cmp_q[$];
  req_t mon_req;
  cmp_t mon_cmp;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_hs = 0;
  int   hs0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    core_bus_lock    = 1'b0;
    core_memory_mode = 1'b0;
    core_address     = '0;
    core_mask        = '0;
    core_data_out    = '0;
  endtask

  task automatic core_issue(input logic w, input logic [29:0] a, input logic [3:0] m,
                            input logic [31:0] d);
    core_bus_lock    = 1'b1;
    core_memory_mode = w;
    core_address     = a;
    core_mask        = m;
    core_data_out    = d;
    exp_req_q.push_back('{w: w, a: a, m: m, d: d});
  endtask

  task automatic expect_done(input logic [31:0] data, input logic err);
    exp_cmp_q.push_back('{data: data, err: err});
  endtask

  // Monitor: request handshakes and completions (DONE with core released).
  always @(negedge clk) begin
    if (async_rst_n) begin
      if (req_valid && req_ready) begin
        n_hs = n_hs + 1;
        if (exp_req_q.size() == 0) begin
          n_chk = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_req: got addr %h, expected no request", req_addr);
        end else begin
          mon_req = exp_req_q.pop_front();
          chk("req_write", {31'd0, req_write}, {31'd0, mon_req.w});
          chk("req_addr", {2'd0, req_addr}, {2'd0, mon_req.a});
          chk("req_mask", {28'd0, req_mask}, {28'd0, mon_req.m});
          chk("req_wdata", req_wdata, mon_req.d);
        end
      end
      if (busy && core_clk_en) begin
        if (exp_cmp_q.size() == 0) begin
          n_chk = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_done: got data %h, expected no completion", core_data_in);
        end else begin
          mon_cmp = exp_cmp_q.pop_front();
          chk("done_data", core_data_in, mon_cmp.data);
          chk("done_err", {31'd0, bus_error}, {31'd0, mon_cmp.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, expected end of test earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    async_rst_n = 1'b0;
    clk_en_in   = 1'b1;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    err_clr     = 1'b0;
    core_idle();

    // Reset state
    #2;
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    chk("rst_data_in", core_data_in, 32'd0);
    chk("rst_req_addr", {2'd0, req_addr}, 32'd0);
    chk("rst_clk_en", {31'd0, core_clk_en}, 32'd1);
    core_bus_lock = 1'b1;
    #1;
    chk("rst_clk_en_lock", {31'd0, core_clk_en}, 32'd0);
    core_bus_lock = 1'b0;
    #9 async_rst_n = 1'b1;

    // 1: load, zero-wait slave, response one cycle after handshake
    step();
    core_issue(1'b0, 30'h0012_3450, 4'hF, 32'd0);
    expect_done(32'h12345678, 1'b0);
    req_ready = 1'b1;
    @(negedge clk); chk("t1_stall0", {31'd0, core_clk_en}, 32'd0);
    step();
    @(negedge clk); chk("t1_req_valid", {31'd0, req_valid}, 32'd1);
    chk("t1_stall1", {31'd0, core_clk_en}, 32'd0);
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
    @(negedge clk); chk("t1_stall2", {31'd0, core_clk_en}, 32'd0);
    step();
    rsp_valid = 1'b0;
    @(negedge clk); chk("t1_release", {31'd0, core_clk_en}, 32'd1);
    step();
    core_idle();
    @(negedge clk); chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: store, slave stalls 5 cycles; captured fields must not follow core inputs
    step();
    hs0 = n_hs;
    core_issue(1'b1, 30'h2AAA_5555, 4'b0011, 32'hAABBCCDD);
    expect_done(32'h12345678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        core_address = 30'h1111_1111; core_data_out = 32'h0; core_mask = 4'hF;
      end
      @(negedge clk);
      chk("t2_valid_hold", {31'd0, req_valid}, 32'd1);
      chk("t2_write_hold", {31'd0, req_write}, 32'd1);
      chk("t2_addr_hold", {2'd0, req_addr}, 32'h2AAA_5555);
      chk("t2_mask_hold", {28'd0, req_mask}, 32'h3);
      chk("t2_wdata_hold", req_wdata, 32'hAABBCCDD);
    end
    step();
    req_ready = 1'b1;
    @(negedge clk);
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h55555555;
    @(negedge clk); chk("t2_valid_drop", {31'd0, req_valid}, 32'd0);
    step();
    rsp_valid = 1'b0;
    @(negedge clk); chk("t2_store_data_kept", core_data_in, 32'h12345678);
    step();
    core_idle();
    @(negedge clk); chk("t2_handshakes", n_hs - hs0, 32'd1);

    // 3: timeout after 8 cycles in REQ/WAIT, late responses dropped, err_clr
    step();
    core_issue(1'b0, 30'h0000_0ABC, 4'hF, 32'd0);
    expect_done(32'hDEADBEEF, 1'b1);
    req_ready = 1'b1;
    step();
    @(negedge clk); chk("t3_req_valid", {31'd0, req_valid}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) req_ready = 1'b0;
      @(negedge clk);
      chk("t3_busy", {31'd0, busy}, 32'd1);
      chk("t3_stall", {31'd0, core_clk_en}, 32'd0);
      chk("t3_err_pending", {31'd0, bus_error}, 32'd0);
    end
    step();
    rsp_valid = 1'b1; rsp_rdata = 32'h11111111;
    @(negedge clk); chk("t3_done", {31'd0, core_clk_en}, 32'd1);
    step();
    core_idle(); rsp_rdata = 32'h22222222;
    @(negedge clk); chk("t3_idle", {31'd0, busy}, 32'd0);
    step();
    rsp_valid = 1'b0; err_clr = 1'b1;
    @(negedge clk); chk("t3_late_dropped", core_data_in, 32'hDEADBEEF);
    chk("t3_err_before_clr", {31'd0, bus_error}, 32'd1);
    step();
    err_clr = 1'b0;
    @(negedge clk); chk("t3_err_cleared", {31'd0, bus_error}, 32'd0);

    // 5: response in the handshake cycle, launch with clk_en_in=0, DONE held 4 cycles
    step();
    clk_en_in = 1'b0;
    core_issue(1'b0, 30'h0000_0042, 4'h1, 32'd0);
    expect_done(32'h0BADF00D, 1'b0);
    req_ready = 1'b1;
    step();
    rsp_valid = 1'b1; rsp_rdata = 32'h0BADF00D;
    @(negedge clk); chk("t5_req_valid", {31'd0, req_valid}, 32'd1);
    step();
    rsp_valid = 1'b0; req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_hold_busy", {31'd0, busy}, 32'd1);
      chk("t5_hold_stall", {31'd0, core_clk_en}, 32'd0);
      chk("t5_no_reissue", {31'd0, req_valid}, 32'd0);
      step();
    end
    clk_en_in = 1'b1;
    @(negedge clk); chk("t5_release", {31'd0, core_clk_en}, 32'd1);
    step();
    core_idle();
    @(negedge clk); chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_idle_no_req", {31'd0, req_valid}, 32'd0);

    // 4: error response with simultaneous err_clr; set wins
    step();
    core_issue(1'b0, 30'h0000_0100, 4'hF, 32'd0);
    expect_done(32'hDEADBEEF, 1'b1);
    req_ready = 1'b1;
    step();
    @(negedge clk);
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'h33333333;
    err_clr = 1'b1;
    @(negedge clk); chk("t4_err_before", {31'd0, bus_error}, 32'd0);
    step();
    rsp_valid = 1'b0; rsp_err = 1'b0; err_clr = 1'b0;
    @(negedge clk); chk("t4_err_set_wins", {31'd0, bus_error}, 32'd1);
    chk("t4_err_data", core_data_in, 32'hDEADBEEF);
    step();
    core_idle();

    // 6: asynchronous reset mid-WAIT, then a normal access
    step();
    core_issue(1'b1, 30'h0000_0155, 4'hF, 32'h01020304);
    req_ready = 1'b1;
    step();
    @(negedge clk);
    step();
    req_ready = 1'b0;
    @(negedge clk); chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    chk("t6_err_pre", {31'd0, bus_error}, 32'd1);
    #2 async_rst_n = 1'b0;
    #1;
    chk("t6_rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_err", {31'd0, bus_error}, 32'd0);
    chk("t6_rst_data", core_data_in, 32'd0);
    chk("t6_rst_req_write", {31'd0, req_write}, 32'd0);
    chk("t6_rst_clk_en_lock", {31'd0, core_clk_en}, 32'd0);
    core_idle();
    step();
    #2 async_rst_n = 1'b1;
    step();
    core_issue(1'b0, 30'h0000_0777, 4'hC, 32'd0);
    expect_done(32'hCAFEF00D, 1'b0);
    req_ready = 1'b1;
    step();
    @(negedge clk);
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    step();
    rsp_valid = 1'b0;
    @(negedge clk); chk("t6_post_data", core_data_in, 32'hCAFEF00D);
    step();
    core_idle();
    @(negedge clk); chk("t6_post_idle", {31'd0, busy}, 32'd0);

    chk("req_queue_empty", exp_req_q.size(), 32'd0);
    chk("cmp_queue_empty", exp_cmp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
- Sits directly downstream of the core's data-memory port.
- Converts the core's per-cycle data access (bus_lock, memory_mode, data_address, data_mask, data_out) into one outstanding transaction on a valid/ready request channel plus a response channel.
- Returns load data on core_data_in and holds the core frozen through core_clk_en until the access completes.
- Provides a timeout and a sticky error flag.

Parameters:
TIMEOUT_CYCLES, 256, max cycles spent in REQ+WAIT before abort; 0 disables timeout
ERR_DATA, 32'hDEADBEEF, read data returned on timeout or rsp_err

Ports:
clk  in  1  core clock
async_rst_n  in  1  asynchronous active-low reset
clk_en_in  in  1  system clock enable
core_clk_en  out  1  clock enable driven to core clk_en
core_bus_lock  in  1  core data access active this cycle
core_memory_mode  in  1  1=store, 0=load
core_address  in  30  word address
core_mask  in  4  byte enables
core_data_out  in  32  store data, little endian
core_data_in  out  32  load data to core data_in
req_valid  out  1  request valid
req_ready  in  1  request accepted
req_write  out  1  1=store
req_addr  out  30  word address
req_mask  out  4  byte enables
req_wdata  out  32  store data
rsp_valid  in  1  response valid, single-cycle pulse
rsp_rdata  in  32  response data
rsp_err  in  1  response error, qualified by rsp_valid
err_clr  in  1  clears bus_error
bus_error  out  1  sticky error flag
busy  out  1  state != IDLE

Behaviour:
- Reset (async, async_rst_n=0): state=IDLE; req_valid=0; req_write/req_addr/req_mask/req_wdata=0; core_data_in=0; bus_error=0; timeout counter=0. core_clk_en = clk_en_in && !core_bus_lock, as in IDLE.
- core_clk_en is combinational: clk_en_in && ((IDLE && !core_bus_lock) || DONE). In all other states it is 0.
- IDLE:
  - On core_bus_lock=1, capture mode/address/mask/data into the req_* registers, set req_valid=1, go to REQ.
  - clk_en_in is not required to launch.
- REQ:
  - req_valid and the req_* fields stay stable until req_ready=1.
  - On the handshake: req_valid drops next edge, go to WAIT.
  - rsp_valid arriving in the same cycle as req_ready is legal and is treated as completion (go to DONE).
- WAIT:
  - On rsp_valid: latch core_data_in from rsp_rdata. For stores, core_data_in is unchanged.
  - If rsp_err=1: core_data_in=ERR_DATA for loads, and bus_error is set.
  - Go to DONE.
- DONE:
  - core_clk_en=clk_en_in. Stay in DONE until clk_en_in=1, then go to IDLE.
  - core_bus_lock in DONE belongs to the completed access and is ignored, so there is no reissue.
- core_data_in holds its last value until the next load response. Minimum access: 1 cycle IDLE detect + REQ + WAIT + DONE = 3 stalled cycles with zero-latency slave.
- Timeout:
  - The counter resets on entry to REQ and increments each cycle in REQ/WAIT.
  - When count == TIMEOUT_CYCLES-1 without completion: req_valid=0, bus_error=1, core_data_in=ERR_DATA for loads, go to DONE.
- Responses arriving in IDLE, REQ (without handshake) or DONE are dropped silently, including late responses after a timeout.
- bus_error: set by a timeout or by rsp_valid&&rsp_err. err_clr clears it; a same-cycle set wins.
- Exactly one outstanding transaction; the bridge never pipelines requests.
- Reset mid-transaction aborts immediately: req_valid=0 asynchronously. The slave must tolerate an abandoned request.

Test Plan:
1. Load, slave ready=1, rsp next cycle with rdata=0x12345678 -> req_write=0, req_addr=core_address; core_clk_en low 3 cycles then high 1 cycle; core_data_in=0x12345678.
2. Store of 0xAABBCCDD, mask 4'b0011, slave holds req_ready=0 for 5 cycles -> req fields stable all 5 cycles; exactly one handshake; core_data_in unchanged.
3. TIMEOUT_CYCLES=8, slave never responds -> abort after 8 cycles in REQ/WAIT; bus_error=1; core_data_in=0xDEADBEEF; late rsp_valid is ignored; err_clr then clears bus_error.
4. Load with rsp_err=1 -> core_data_in=ERR_DATA, bus_error=1; a simultaneous err_clr leaves bus_error=1.
5. In DONE hold clk_en_in=0 for 4 cycles -> stays in DONE, no new req_valid; leaves on first clk_en_in=1.
6. Assert async_rst_n low mid-WAIT, between edges -> req_valid, busy and bus_error go to 0 without a clock edge; first access after reset completes normally.
